// File: rtl/dmem_access_unit.sv
// M-stage data-memory access controller: turns a load/store request into one
// valid/ready bus transaction and stalls the pipeline until it completes.
module dmem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        ErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t        state;
  logic [29:0]   addrQ;
  logic [31:0]   wdataQ;
  logic [31:0]   rdataQ;
  logic          weQ;
  logic          reqQ;
  logic          errQ;
  logic [CW-1:0] cnt;

  logic acc;
  logic aligned;

  assign acc     = MemReadM | MemWriteM;
  assign aligned = (ALUResultM[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      addrQ  <= '0;
      wdataQ <= '0;
      rdataQ <= '0;
      weQ    <= 1'b0;
      reqQ   <= 1'b0;
      errQ   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && aligned) begin
            addrQ  <= ALUResultM[31:2];
            wdataQ <= WriteDataM;
            weQ    <= MemWriteM;
            reqQ   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            reqQ <= 1'b0;
            if (weQ) begin
              state <= DONE;
            end else begin
              cnt   <= '0;
              state <= RESP;
            end
          end
        end
        RESP: begin
          // Counter stops at CNT_LAST because the timeout exits RESP there.
          if (bus_rvalid) begin
            rdataQ <= bus_rdata;
            state  <= DONE;
          end else if (cnt == CNT_LAST) begin
            rdataQ <= 32'hDEAD_BEEF;
            errQ   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          errQ  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by reset so the stall releases the instant reset asserts.
  assign StallM    = reset & (((state == IDLE) & acc & aligned) |
                              (state == REQ) | (state == RESP));
  assign MisalignM = reset & (state == IDLE) & acc & ~aligned;
  assign ErrM      = (state == DONE) & errQ;
  assign ReadDataM = MisalignM ? '0 : rdataQ;

  assign bus_req   = reqQ;
  assign bus_we    = weQ;
  assign bus_addr  = {addrQ, 2'b00};
  assign bus_wdata = wdataQ;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit (TIMEOUT = 4): stores, loads with bus
// wait states, misalignment, timeout, mid-transaction reset, back-to-back.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignM, ErrM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .ErrM(ErrM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  // Drive one cycle's inputs at the falling edge, then let outputs settle.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy, input logic rv,
                      input logic [31:0] rdt);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; ALUResultM = a; WriteDataM = d;
    bus_ready = rdy; bus_rvalid = rv; bus_rdata = rdt;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vectors++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", bus_req); end
    vectors++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", bus_we); end
    vectors++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", bus_addr); end
    vectors++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%h exp=0", bus_wdata); end
    vectors++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", ReadDataM); end
    vectors++; if ({StallM, MisalignM, ErrM} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {StallM, MisalignM, ErrM}); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_store;
    step(0, 1, 32'h100, 32'hCAFEF00D, 0, 0, 32'h0);   // cycle 1: IDLE
    vectors++; if (StallM !== 1'b1) begin errors++; $display("FAIL st_c1_stall got=%b exp=1", StallM); end
    vectors++; if (bus_req !== 1'b0) begin errors++; $display("FAIL st_c1_req got=%b exp=0", bus_req); end
    step(0, 1, 32'h100, 32'hCAFEF00D, 1, 0, 32'h0);   // cycle 2: REQ, accepted
    vectors++; if ({bus_req, bus_we} !== 2'b11) begin errors++; $display("FAIL st_c2_reqwe got=%b exp=11", {bus_req, bus_we}); end
    vectors++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL st_c2_addr got=%h exp=00000100", bus_addr); end
    vectors++; if (bus_wdata !== 32'hCAFEF00D) begin errors++; $display("FAIL st_c2_wdata got=%h exp=cafef00d", bus_wdata); end
    vectors++; if (StallM !== 1'b1) begin errors++; $display("FAIL st_c2_stall got=%b exp=1", StallM); end
    step(0, 1, 32'h100, 32'hCAFEF00D, 0, 0, 32'h0);   // cycle 3: DONE
    vectors++; if ({StallM, bus_req} !== 2'b00) begin errors++; $display("FAIL st_c3 stall,req got=%b exp=00", {StallM, bus_req}); end
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vectors++; if (StallM !== 1'b0) begin errors++; $display("FAIL st_idle_stall got=%b exp=0", StallM); end
  endtask

  task automatic test_load_wait;
    int unsigned stalls = 0;
    for (int c = 1; c <= 8; c++) begin
      step(1, 0, 32'h204, 32'h0, c == 5, c == 7, (c == 7) ? 32'h12345678 : 32'hFFFF0000);
      if (StallM === 1'b1) stalls++;
      if (c >= 2 && c <= 5) begin
        vectors++; if ({bus_req, bus_we} !== 2'b10 || bus_addr !== 32'h204) begin
          errors++; $display("FAIL ld_req c=%0d req/we=%b addr=%h exp 10/00000204", c, {bus_req, bus_we}, bus_addr);
        end
      end
      if (c == 6) begin
        vectors++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ld_resp_req got=%b exp=0", bus_req); end
      end
      if (c == 8) begin
        vectors++; if (ReadDataM !== 32'h12345678) begin errors++; $display("FAIL ld_data got=%h exp=12345678", ReadDataM); end
        vectors++; if ({StallM, ErrM} !== 2'b00) begin errors++; $display("FAIL ld_done stall,err got=%b exp=00", {StallM, ErrM}); end
      end
    end
    vectors++; if (stalls != 7) begin errors++; $display("FAIL ld_stall_cycles got=%0d exp=7", stalls); end
  endtask

  task automatic test_misalign;
    step(1, 0, 32'h102, 32'h0, 1, 0, 32'h0);
    vectors++; if ({MisalignM, StallM, bus_req} !== 3'b100) begin errors++; $display("FAIL mis_flags mis,stall,req got=%b exp=100", {MisalignM, StallM, bus_req}); end
    vectors++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL mis_rdata got=%h exp=0", ReadDataM); end
    step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    vectors++; if ({MisalignM, bus_req} !== 2'b00) begin errors++; $display("FAIL mis_after mis,req got=%b exp=00", {MisalignM, bus_req}); end
    vectors++; if (ReadDataM !== 32'h12345678) begin errors++; $display("FAIL mis_hold got=%h exp=12345678", ReadDataM); end
  endtask

  task automatic test_timeout;
    step(1, 0, 32'h300, 32'h0, 0, 0, 32'h0);          // IDLE
    step(1, 0, 32'h300, 32'h0, 1, 0, 32'h0);          // REQ accepted
    for (int c = 0; c < 4; c++) begin                 // four RESP cycles
      step(1, 0, 32'h300, 32'h0, 0, 0, 32'h0);
      vectors++; if ({StallM, ErrM} !== 2'b10) begin errors++; $display("FAIL to_resp c=%0d stall,err got=%b exp=10", c, {StallM, ErrM}); end
    end
    step(1, 0, 32'h300, 32'h0, 0, 0, 32'h0);          // DONE
    vectors++; if ({StallM, ErrM} !== 2'b01) begin errors++; $display("FAIL to_done stall,err got=%b exp=01", {StallM, ErrM}); end
    vectors++; if (ReadDataM !== 32'hDEADBEEF) begin errors++; $display("FAIL to_data got=%h exp=deadbeef", ReadDataM); end
    step(0, 0, 32'h0, 32'h0, 0, 1, 32'h55555555);     // stray rvalid in IDLE
    vectors++; if ({StallM, ErrM, bus_req} !== 3'b000) begin errors++; $display("FAIL to_idle stall,err,req got=%b exp=000", {StallM, ErrM, bus_req}); end
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vectors++; if (ReadDataM !== 32'hDEADBEEF) begin errors++; $display("FAIL to_stray got=%h exp=deadbeef", ReadDataM); end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 32'h400, 32'h0, 0, 0, 32'h0);
    step(1, 0, 32'h400, 32'h0, 1, 0, 32'h0);
    step(1, 0, 32'h400, 32'h0, 0, 0, 32'h0);          // RESP
    vectors++; if (StallM !== 1'b1) begin errors++; $display("FAIL rm_resp_stall got=%b exp=1", StallM); end
    #1 reset = 1'b0; MemReadM = 1'b0;
    #1;
    vectors++; if ({bus_req, StallM} !== 2'b00) begin errors++; $display("FAIL rm_async req,stall got=%b exp=00", {bus_req, StallM}); end
    @(negedge clk); reset = 1'b1;
    step(0, 0, 32'h0, 32'h0, 0, 1, 32'h77777777);     // late rvalid
    vectors++; if ({StallM, bus_req} !== 2'b00) begin errors++; $display("FAIL rm_idle stall,req got=%b exp=00", {StallM, bus_req}); end
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    vectors++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL rm_late got=%h exp=0", ReadDataM); end
    step(1, 0, 32'h40, 32'h0, 0, 0, 32'h0);
    vectors++; if (StallM !== 1'b1) begin errors++; $display("FAIL rm_ld_stall got=%b exp=1", StallM); end
    step(1, 0, 32'h40, 32'h0, 1, 0, 32'h0);
    vectors++; if (bus_req !== 1'b1 || bus_addr !== 32'h40) begin errors++; $display("FAIL rm_ld_req req=%b addr=%h exp 1/00000040", bus_req, bus_addr); end
    step(1, 0, 32'h40, 32'h0, 0, 1, 32'hA5A5A5A5);
    step(1, 0, 32'h40, 32'h0, 0, 0, 32'h0);
    vectors++; if (ReadDataM !== 32'hA5A5A5A5 || StallM !== 1'b0) begin errors++; $display("FAIL rm_ld_done data=%h stall=%b exp a5a5a5a5/0", ReadDataM, StallM); end
  endtask

  task automatic test_both;
    step(1, 1, 32'h80, 32'h0BADF00D, 0, 0, 32'h0);
    vectors++; if (StallM !== 1'b1) begin errors++; $display("FAIL both_c1 got=%b exp=1", StallM); end
    step(1, 1, 32'h80, 32'h0BADF00D, 1, 0, 32'h0);
    vectors++; if ({bus_req, bus_we} !== 2'b11 || bus_addr !== 32'h80) begin errors++; $display("FAIL both_req req/we=%b addr=%h exp 11/00000080", {bus_req, bus_we}, bus_addr); end
    step(1, 1, 32'h80, 32'h0BADF00D, 0, 1, 32'h99999999);
    vectors++; if (StallM !== 1'b0) begin errors++; $display("FAIL both_done_stall got=%b exp=0", StallM); end
    vectors++; if (ReadDataM !== 32'hA5A5A5A5) begin errors++; $display("FAIL both_rdata got=%h exp=a5a5a5a5", ReadDataM); end
  endtask

  task automatic test_back_to_back;
    step(0, 1, 32'h10, 32'h11112222, 0, 0, 32'h0);
    step(0, 1, 32'h10, 32'h11112222, 1, 0, 32'h0);
    step(0, 1, 32'h10, 32'h11112222, 0, 0, 32'h0);    // DONE of store
    step(1, 0, 32'h14, 32'h0, 0, 0, 32'h0);           // next access in IDLE
    vectors++; if (StallM !== 1'b1) begin errors++; $display("FAIL b2b_idle_stall got=%b exp=1", StallM); end
    step(1, 0, 32'h14, 32'h0, 1, 0, 32'h0);
    vectors++; if ({bus_req, bus_we} !== 2'b10 || bus_addr !== 32'h14) begin errors++; $display("FAIL b2b_req req/we=%b addr=%h exp 10/00000014", {bus_req, bus_we}, bus_addr); end
    step(1, 0, 32'h14, 32'h0, 0, 1, 32'h13572468);
    step(1, 0, 32'h14, 32'h0, 0, 0, 32'h0);
    vectors++; if (ReadDataM !== 32'h13572468 || StallM !== 1'b0) begin errors++; $display("FAIL b2b_done data=%h stall=%b exp 13572468/0", ReadDataM, StallM); end
    step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    MemReadM = 1'b0; MemWriteM = 1'b0; ALUResultM = '0; WriteDataM = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    test_reset();
    test_store();
    test_load_wait();
    test_misalign();
    test_timeout();
    test_reset_mid();
    test_both();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Memory-stage data-access controller for the pipelined RV32 core. It takes the M-stage access request (MemWriteM, MemReadM, ALUResultM, WriteDataM) and runs it as a transaction on a valid/ready data bus. It holds the pipeline with StallM until the transaction completes, then returns ReadDataM to the M/W pipeline register. It also handles misaligned word accesses and bus response timeouts.

## Interface
Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for bus_rvalid in RESP; must be ≥2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemReadM  in  1  M-stage load request.
- MemWriteM  in  1  M-stage store request.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load result to the M/W register.
- StallM  out  1  freezes the PC and the F/D, D/E and E/M registers; the M/W register captures a bubble while high.
- MisalignM  out  1  pulse: the M-stage access was dropped because ALUResultM[1:0] != 0.
- ErrM  out  1  pulse: a load timed out.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = store, 0 = load.
- bus_addr  out  32  word address, bits [1:0] = 0.
- bus_wdata  out  32  store data.
- bus_ready  in  1  bus accepts the request in this cycle.
- bus_rvalid  in  1  load data is valid.
- bus_rdata  in  32  load data.

## Operation
- Access present: acc = MemReadM | MemWriteM. If both are high, the access is a store.
- State machine: IDLE, REQ, RESP, DONE.
- IDLE, acc high and address aligned:
  - StallM = 1, combinational from the inputs.
  - Latch addr, wdata and we on this edge; next state REQ.
- IDLE, acc high and misaligned:
  - No bus activity and StallM = 0.
  - MisalignM = 1 for this cycle; ReadDataM = 0 for this cycle; stay in IDLE.
- IDLE, acc low: StallM = 0; stay in IDLE.
- REQ:
  - bus_req = 1; bus_addr, bus_we and bus_wdata come from the latched registers and stay stable until accepted.
  - StallM = 1.
  - On bus_ready: a store goes to DONE; a load clears the timeout counter and goes to RESP.
- RESP:
  - bus_req = 0; StallM = 1; the counter increments every cycle.
  - On bus_rvalid: capture bus_rdata into rdata_q; next state DONE.
  - If the counter reaches TIMEOUT-1 with bus_rvalid low: capture 32'hDEAD_BEEF; set err_q; next state DONE.
- DONE:
  - StallM = 0; ReadDataM = rdata_q; ErrM = err_q.
  - Clear err_q; next state IDLE.
  - The pipeline advances on this edge, so IDLE next sees the following instruction.
- Outside DONE, and outside the misaligned case, ReadDataM = rdata_q, which holds the last captured value.
- bus_rvalid is ignored outside RESP. Stray responses are dropped.
- bus_rdata is ignored for stores.
- The counter width is $clog2(TIMEOUT); the counter saturates and never wraps inside RESP.

## Timing
- Reset (reset = 0), asynchronous: state = IDLE; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0; rdata_q = 0; err_q = 0; counter = 0.
  - StallM, MisalignM and ErrM are 0 once the request inputs are low.
  - Reset in the middle of a transaction drops bus_req immediately and abandons the transaction; a late bus_rvalid after reset is ignored.
- Store, bus_ready in the first REQ cycle: stall high for 2 cycles (IDLE, REQ); DONE in cycle 3; M occupancy is 3 cycles.
- Load, bus_ready in the first REQ cycle, bus_rvalid k cycles later (k ≥ 1): stall high for 2+k cycles; ReadDataM is valid in the DONE cycle.
- bus_ready low for n cycles: REQ extends by n cycles with the bus fields unchanged.
- Timeout: RESP lasts exactly TIMEOUT cycles; ErrM is high only in the following DONE cycle.
- Back-to-back accesses: DONE → IDLE → a new access stalls in that IDLE cycle; there is no idle cycle on the bus beyond the protocol minimum.
- Non-memory instructions never stall; there is zero added latency.

## Test plan
- Reset, then a store: addr 0x100, data 0xCAFEF00D, bus_ready in cycle 2.
  - Required: bus_req, bus_we, addr 0x100 and wdata 0xCAFEF00D in cycle 2; StallM high in cycles 1-2; low in cycle 3.
- Load: addr 0x204, bus_ready held low for 3 cycles, then high; bus_rvalid 2 cycles later with 0x12345678.
  - Required: bus_addr stable at 0x204 throughout; StallM high for 7 cycles; ReadDataM = 0x12345678 in DONE.
- Load at addr 0x102.
  - Required: MisalignM = 1 and ReadDataM = 0 in the same cycle; StallM = 0; bus_req never asserts.
- TIMEOUT = 4, load accepted with no bus_rvalid.
  - Required: 4 RESP cycles; ReadDataM = 0xDEADBEEF and ErrM = 1 for one cycle in DONE. A bus_rvalid pulse in the next IDLE cycle is ignored.
- reset asserted while in RESP.
  - Required: bus_req = 0 and StallM = 0 immediately; state is IDLE after release. A following load to 0x40 completes normally.
- MemReadM and MemWriteM both high at 0x80.
  - Required: bus_we = 1; no RESP state; 3-cycle occupancy.
